dds_sweep_ctrl: RTL and testbench

//  Frequency-sweep sequencer for the DDS core. Latches a sweep profile on start, drives Fword/Pword
//  and the DDS's active-high reset, and steps Fword from f_start to f_stop every dwell cycles.

---
 rtl/dds_sweep_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_dds_sweep_ctrl.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/dds_sweep_ctrl.sv
// dds_sweep_ctrl: frequency-sweep sequencer for the DDS core.
// Latches a sweep profile on start, drives Fword/Pword and the DDS reset,
// and steps Fword from f_start towards f_stop, holding each value for a
// programmable dwell.
// Optional build macro: SWEEP_TRIANGLE_EN (up/down triangle sweep instead
// of sawtooth; the direction register exists only in that build).
//
// state | meaning
// IDLE  | DDS held in reset, waiting for start
// ALIGN | one cycle: load first Fword/Pword, DDS still in reset
// RUN   | DDS running, Fword stepped every dwell cycles
// DONE  | single sweep finished, DDS held in reset, start re-arms
module dds_sweep_ctrl #(
    parameter int FW = 8,
    parameter int PW = 9,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          abort,
    input  logic          cont,
    input  logic [FW-1:0] f_start,
    input  logic [FW-1:0] f_stop,
    input  logic [FW-1:0] f_step,
    input  logic [PW-1:0] p_offset,
    input  logic [DW-1:0] dwell,
    output logic [FW-1:0] Fword,
    output logic [PW-1:0] Pword,
    output logic          dds_reset,
    output logic          busy,
    output logic          done,
    output logic          wrap
);

    typedef enum logic [1:0] {IDLE, ALIGN, RUN, DONE} state_t;

    state_t state, state_next;

    logic [FW-1:0] sh_start, sh_stop, sh_step;
    logic [PW-1:0] sh_poff;
    logic [DW-1:0] sh_dwell;
    logic          sh_cont;
    logic [DW-1:0] cnt;

    logic          busy_d, dds_reset_d, done_d, wrap_d;
    logic          degen, dwell_end, sweep_end;
    logic [FW:0]   sum;
    logic [FW-1:0] up_val;

`ifdef SWEEP_TRIANGLE_EN
    logic          dir_down;
    logic [FW:0]   dn_floor;
    logic [FW-1:0] dn_val;
`endif

    // Sweep datapath helpers; the sum is one bit wider so overflow clamps to f_stop
    always_comb begin
        degen     = (sh_stop <= sh_start) || (sh_step == '0);
        dwell_end = (cnt == '0);
        sum       = {1'b0, Fword} + {1'b0, sh_step};
        up_val    = (sum > {1'b0, sh_stop}) ? sh_stop : sum[FW-1:0];
`ifdef SWEEP_TRIANGLE_EN
        // Compare before subtracting so a step below f_start clamps instead of underflowing
        dn_floor  = {1'b0, sh_start} + {1'b0, sh_step};
        dn_val    = ({1'b0, Fword} < dn_floor) ? sh_start : (Fword - sh_step);
        sweep_end = (state == RUN) && dwell_end &&
                    (degen || (dir_down && (Fword == sh_start)));
`else
        sweep_end = (state == RUN) && dwell_end && (degen || (Fword == sh_stop));
`endif
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    // Next-state logic; abort wins over start and over end of sweep
    always_comb begin
        state_next = state;
        case (state)
            IDLE, DONE: if (start) state_next = ALIGN;
            ALIGN:      state_next = abort ? IDLE : RUN;
            RUN: begin
                if (abort)                      state_next = IDLE;
                else if (sweep_end && !sh_cont) state_next = DONE;
            end
            default:    state_next = IDLE;
        endcase
    end

    // Output decode; values are registered below so every output is a flop.
    // dds_reset drops only on the second RUN cycle, one edge after Fword is valid.
    always_comb begin
        busy_d      = (state_next == ALIGN) || (state_next == RUN);
        dds_reset_d = !((state == RUN) && (state_next == RUN));
        done_d      = (state == RUN) && (state_next == DONE);
        wrap_d      = (state == RUN) && !abort && sweep_end && sh_cont;
    end

    // Output registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy      <= 1'b0;
            dds_reset <= 1'b1;
            done      <= 1'b0;
            wrap      <= 1'b0;
        end else begin
            busy      <= busy_d;
            dds_reset <= dds_reset_d;
            done      <= done_d;
            wrap      <= wrap_d;
        end
    end

    // Profile shadow registers, dwell down-counter and Fword/Pword stepping
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sh_start <= '0;
            sh_stop  <= '0;
            sh_step  <= '0;
            sh_poff  <= '0;
            sh_dwell <= '0;
            sh_cont  <= 1'b0;
            cnt      <= '0;
            Fword    <= '0;
            Pword    <= '0;
`ifdef SWEEP_TRIANGLE_EN
            dir_down <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        sh_start <= f_start;
                        sh_stop  <= f_stop;
                        sh_step  <= f_step;
                        sh_poff  <= p_offset;
                        sh_dwell <= (dwell == '0) ? DW'(1) : dwell;
                        sh_cont  <= cont;
                    end
                end
                ALIGN: begin
                    if (!abort) begin
                        Fword <= sh_start;
                        Pword <= sh_poff;
                        cnt   <= sh_dwell - DW'(1);
`ifdef SWEEP_TRIANGLE_EN
                        dir_down <= 1'b0;
`endif
                    end
                end
                RUN: begin
                    if (!abort) begin
                        if (dwell_end) begin
                            cnt <= sh_dwell - DW'(1);
`ifdef SWEEP_TRIANGLE_EN
                            if (sweep_end) begin
                                if (sh_cont) begin
                                    dir_down <= 1'b0;
                                    Fword    <= degen ? sh_start : up_val;
                                end
                            end else if (!dir_down) begin
                                if (Fword == sh_stop) begin
                                    dir_down <= 1'b1;
                                    Fword    <= dn_val;
                                end else begin
                                    Fword <= up_val;
                                end
                            end else begin
                                Fword <= dn_val;
                            end
`else
                            if (sweep_end) begin
                                if (sh_cont) Fword <= sh_start;
                            end else begin
                                Fword <= up_val;
                            end
`endif
                        end else begin
                            cnt <= cnt - DW'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Self-checking bench for dds_sweep_ctrl (default sawtooth build).
// The reference model expands a profile into its list of Fword values and
// predicts each cycle's outputs from the position in that list.
module tb_dds_sweep_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        start, abort, cont;
    logic [7:0]  f_start, f_stop, f_step;
    logic [8:0]  p_offset;
    logic [15:0] dwell;
    logic [7:0]  Fword;
    logic [8:0]  Pword;
    logic        dds_reset, busy, done, wrap;

    int checks = 0;
    int errors = 0;
    int exp_f  = 0;
    int exp_p  = 0;

    dds_sweep_ctrl #(.FW(8), .PW(9), .DW(16)) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort), .cont(cont),
        .f_start(f_start), .f_stop(f_stop), .f_step(f_step),
        .p_offset(p_offset), .dwell(dwell),
        .Fword(Fword), .Pword(Pword), .dds_reset(dds_reset),
        .busy(busy), .done(done), .wrap(wrap)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // One sweep from start pulse to done (or abort). abort_in: number of RUN
    // sample points before abort is raised (0 = abort during ALIGN, <0 = none).
    task automatic run_sweep(input int fs, input int fe, input int fst, input int po,
                             input int dw, input bit c, input int abort_in, input int ncyc);
        int q[$];
        int d, len, v, total, abort_at, ef;
        if (fe <= fs || fst == 0) begin
            q.push_back(fs);
        end else begin
            v = fs;
            q.push_back(v);
            while (v != fe) begin
                v = (v + fst > fe) ? fe : v + fst;
                q.push_back(v);
            end
        end
        d   = (dw == 0) ? 1 : dw;
        len = q.size() * d;
        abort_at = abort_in;
        if (c && abort_at < 0) abort_at = ncyc;
        if (!c && abort_at >= len) abort_at = -1;

        f_start = 8'(fs); f_stop = 8'(fe); f_step = 8'(fst);
        p_offset = 9'(po); dwell = 16'(dw); cont = c;
        start = 1'b1;
        step();
        start = 1'b0;
        // Scramble the profile inputs: the latched copy must be used
        f_start = 8'($urandom); f_stop = 8'($urandom); f_step = 8'($urandom);
        p_offset = 9'($urandom); dwell = 16'($urandom_range(0, 5)); cont = 1'($urandom);
        chk("align_busy", busy, 1);
        chk("align_rst", dds_reset, 1);
        chk("align_done", done, 0);

        if (abort_at == 0) begin
            abort = 1'b1;
            step();
            abort = 1'b0;
            chk("abort_busy", busy, 0);
            chk("abort_rst", dds_reset, 1);
            chk("abort_fword", Fword, exp_f);
            chk("abort_pword", Pword, exp_p);
            chk("abort_done", done, 0);
            return;
        end

        step();
        exp_f = q[0];
        exp_p = po;
        chk("first_fword", Fword, exp_f);
        chk("pword", Pword, exp_p);
        chk("first_rst", dds_reset, 1);
        chk("first_busy", busy, 1);

        total = (abort_at >= 0) ? abort_at : len;
        for (int k = 1; k < total; k++) begin
            start = 1'($urandom_range(0, 1));
            step();
            ef = q[(k % len) / d];
            chk("run_fword", Fword, ef);
            chk("run_rst", dds_reset, 0);
            chk("run_busy", busy, 1);
            chk("run_done", done, 0);
            chk("run_wrap", wrap, (k % len == 0) ? 1 : 0);
            exp_f = ef;
        end
        start = 1'b0;

        if (abort_at >= 0) begin
            abort = 1'b1;
            step();
            abort = 1'b0;
            chk("abort_busy", busy, 0);
            chk("abort_rst", dds_reset, 1);
            chk("abort_fword", Fword, exp_f);
            chk("abort_done", done, 0);
            chk("abort_wrap", wrap, 0);
            step();
            chk("idle_done", done, 0);
            chk("idle_busy", busy, 0);
        end else begin
            step();
            chk("end_done", done, 1);
            chk("end_busy", busy, 0);
            chk("end_rst", dds_reset, 1);
            chk("end_fword", Fword, exp_f);
            chk("end_pword", Pword, exp_p);
            chk("end_wrap", wrap, 0);
            step();
            chk("post_done", done, 0);
            chk("post_busy", busy, 0);
            chk("post_rst", dds_reset, 1);
        end
    endtask

    initial begin
        int fs, fe, fst, dw, nc, ab;
        bit c;
        reset = 1'b0; start = 1'b0; abort = 1'b0; cont = 1'b0;
        f_start = '0; f_stop = '0; f_step = '0; p_offset = '0; dwell = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_fword", Fword, 0);
        chk("rst_pword", Pword, 0);
        chk("rst_dds", dds_reset, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_wrap", wrap, 0);
        reset = 1'b1;
        step();

        run_sweep(10, 40, 10, 255, 4, 1'b0, -1, 0);
        run_sweep(250, 255, 4, 17, 2, 1'b0, -1, 0);
        run_sweep(1, 3, 1, 0, 1, 1'b1, -1, 12);
        run_sweep(10, 40, 10, 255, 4, 1'b0, 6, 0);
        run_sweep(9, 5, 7, 3, 0, 1'b0, -1, 0);
        run_sweep(20, 60, 20, 100, 2, 1'b0, 0, 0);
        run_sweep(33, 33, 5, 7, 3, 1'b1, -1, 10);
        run_sweep(40, 90, 0, 8, 1, 1'b0, -1, 0);

        // Asynchronous reset in the middle of RUN
        f_start = 8'd10; f_stop = 8'd40; f_step = 8'd10; p_offset = 9'd255;
        dwell = 16'd4; cont = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (3) step();
        #2 reset = 1'b0;
        #1;
        chk("arst_fword", Fword, 0);
        chk("arst_pword", Pword, 0);
        chk("arst_dds", dds_reset, 1);
        chk("arst_busy", busy, 0);
        chk("arst_done", done, 0);
        chk("arst_wrap", wrap, 0);
        reset = 1'b1;
        step();
        exp_f = 0;
        exp_p = 0;

        for (int r = 0; r < 10; r++) begin
            fs  = $urandom_range(0, 255);
            fe  = $urandom_range(0, 255);
            fst = $urandom_range(0, 60);
            dw  = $urandom_range(0, 3);
            c   = 1'($urandom_range(0, 1));
            nc  = $urandom_range(3, 40);
            ab  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 8) : -1;
            run_sweep(fs, fe, fst, $urandom_range(0, 511), dw, c, ab, nc);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
